// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Purpose  : Shared types and constants for the PS/2 receive path.
//             Holds the frame FSM state encoding, the scan-code prefix bytes
//             and the key-event record that is queued towards the consumer.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
package ps2_pkg;

    // Frame FSM states, explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // Scan-code set 2 prefix bytes.
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // One decoded key event as stored in the FIFO.
    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } key_event_t;

    // PS/2 uses odd parity across the 8 data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_event_fifo
//  Purpose  : Key-event FIFO with registered head outputs.
//  Ports    : Clk, Reset_n         - clock, asynchronous active-low reset
//             push, push_data      - write request and event to store
//             push_drop            - strobe: push rejected because full
//             pop_ready            - consumer accepts the head entry
//             head_valid, head     - registered head entry and its valid flag
//             count                - number of occupied entries
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          push,
    input  key_event_t                    push_data,
    output logic                          push_drop,
    input  logic                          pop_ready,
    output logic                          head_valid,
    output key_event_t                    head,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int              c_aw      = $clog2(FIFO_DEPTH);
    localparam logic [c_aw:0]   c_depth   = c_aw'(0) + (c_aw+1)'(FIFO_DEPTH);
    localparam logic [c_aw:0]   c_cnt_one = (c_aw+1)'(1);
    localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

    key_event_t       r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             r_valid;
    key_event_t       r_head;

    logic             w_pop;
    logic             w_full;
    logic             w_accept;
    logic [c_aw-1:0]  w_rd_inc;
    logic [c_aw:0]    w_count_nxt;
    key_event_t       w_head_nxt;

    assign w_pop    = r_valid & pop_ready;
    assign w_full   = (r_count == c_depth);
    // A full FIFO still takes a push when a pop frees the slot that same cycle.
    assign w_accept = push & (~w_full | w_pop);
    assign w_rd_inc = r_rd_ptr + c_ptr_one;

    assign w_count_nxt = r_count + {{c_aw{1'b0}}, w_accept} - {{c_aw{1'b0}}, w_pop};

    // Head register look-ahead: after a pop the next entry is either already
    // in storage (count >= 2) or is the one being pushed right now.
    always_comb begin
        w_head_nxt = r_head;
        if (w_pop) begin
            if (r_count != c_cnt_one) begin
                w_head_nxt = r_mem[w_rd_inc];
            end else if (w_accept) begin
                w_head_nxt = push_data;
            end
        end else if (!r_valid && w_accept) begin
            w_head_nxt = push_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_head   <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_inc;
            end
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
            r_head  <= w_head_nxt;
        end
    end

    assign push_drop  = push & ~w_accept;
    assign head_valid = r_valid;
    assign head       = r_head;
    assign count      = r_count;

endmodule
`default_nettype wire

// File: rtl/ps2_rx_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_rx_decoder
//  Purpose  : PS/2 keyboard receiver. Synchronises and glitch-filters the
//             PS/2 clock and data pins, frames 11-bit packets (start, 8 data,
//             odd parity, stop), folds E0/F0 prefixes into single key events
//             and queues them behind a valid/ready interface.
//  Ports    : Clk, Reset_n            - system clock, async active-low reset
//             ps2_clk, ps2_data       - raw PS/2 pins (asynchronous)
//             evt_valid, evt_ready    - event handshake
//             evt_code/ext/break      - head event fields
//             fifo_count              - occupied FIFO entries
//             parity_err, frame_err   - single-cycle error strobes
//             overflow, err_clr       - sticky drop flag and its clear
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module ps2_rx_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 5000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_break,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    input  logic                          err_clr
);

    localparam int              c_fw        = $clog2(FILTER_LEN);
    localparam logic [c_fw-1:0] c_flt_last  = c_fw'(FILTER_LEN - 1);
    localparam logic [c_fw-1:0] c_flt_one   = c_fw'(1);
    localparam int              c_tw        = $clog2(TIMEOUT_CYC);
    localparam logic [c_tw-1:0] c_tmo_last  = c_tw'(TIMEOUT_CYC - 1);
    localparam logic [c_tw-1:0] c_tmo_one   = c_tw'(1);

    // ------------------------------------------------------------------
    // Synchroniser + filter, bit 0 = clock line, bit 1 = data line
    // ------------------------------------------------------------------
    logic [1:0] w_pins;
    logic [1:0] w_filt;

    assign w_pins = {ps2_data, ps2_clk};

    for (genvar gi = 0; gi < 2; gi++) begin : g_line
        logic [1:0]      r_sync;
        logic [c_fw-1:0] r_cnt;
        logic            r_filt;

        // The counter tracks how many back-to-back samples disagree with the
        // filtered level; any agreeing sample restarts the count.
        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                r_sync <= 2'b11;
                r_cnt  <= '0;
                r_filt <= 1'b1;
            end else begin
                r_sync <= {r_sync[0], w_pins[gi]};
                if (r_sync[1] == r_filt) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_flt_last) begin
                    r_filt <= r_sync[1];
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + c_flt_one;
                end
            end
        end

        assign w_filt[gi] = r_filt;
    end

    logic r_clk_prev;
    logic w_fall;
    logic w_sdata;

    assign w_fall  = r_clk_prev & ~w_filt[0];
    assign w_sdata = w_filt[1];

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    ps2_state_e      r_state, w_state_nxt;
    logic [2:0]      r_bit_cnt, w_bit_nxt;
    logic [7:0]      r_shift, w_shift_nxt;
    logic            r_par, w_par_nxt;
    logic [c_tw-1:0] r_tmo, w_tmo_nxt;
    logic            w_byte_done;
    logic            w_par_bad;
    logic            w_frm_bad;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_tmo      <= '0;
            r_clk_prev <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_par      <= w_par_nxt;
            r_tmo      <= w_tmo_nxt;
            r_clk_prev <= w_filt[0];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_tmo_nxt   = r_tmo;
        w_byte_done = 1'b0;
        w_par_bad   = 1'b0;
        w_frm_bad   = 1'b0;

        // Watchdog only runs while a frame is in progress.
        if (r_state == IDLE || w_fall) begin
            w_tmo_nxt = '0;
        end else begin
            w_tmo_nxt = r_tmo + c_tmo_one;
        end

        if (r_state != IDLE && !w_fall && r_tmo == c_tmo_last) begin
            w_state_nxt = IDLE;
            w_tmo_nxt   = '0;
            w_frm_bad   = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                IDLE: begin
                    if (!w_sdata) begin
                        w_state_nxt = DATA;
                        w_bit_nxt   = '0;
                    end
                end
                DATA: begin
                    w_shift_nxt = {w_sdata, r_shift[7:1]};
                    w_bit_nxt   = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = PARITY;
                    end
                end
                PARITY: begin
                    w_par_nxt   = w_sdata;
                    w_state_nxt = STOP;
                end
                STOP: begin
                    // A bad stop bit makes the parity bit meaningless.
                    if (!w_sdata) begin
                        w_frm_bad = 1'b1;
                    end else if (odd_parity_ok(r_shift, r_par)) begin
                        w_byte_done = 1'b1;
                    end else begin
                        w_par_bad = 1'b1;
                    end
                    w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered byte strobe, error pulses, prefix decoder
    // ------------------------------------------------------------------
    logic       r_byte_done;
    logic [7:0] r_byte;
    logic       r_ext_pend;
    logic       r_brk_pend;
    logic       w_is_prefix;
    logic       w_push;
    key_event_t w_push_evt;
    logic       w_drop;

    assign w_is_prefix = (r_byte == PS2_EXT) || (r_byte == PS2_BRK);
    assign w_push      = r_byte_done & ~w_is_prefix;
    assign w_push_evt  = {r_byte, r_ext_pend, r_brk_pend};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_byte_done <= 1'b0;
            r_byte      <= '0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            r_ext_pend  <= 1'b0;
            r_brk_pend  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            r_byte_done <= w_byte_done;
            parity_err  <= w_par_bad;
            frame_err   <= w_frm_bad;
            if (w_byte_done) begin
                r_byte <= r_shift;
            end

            // A corrupted frame may have been the key the prefix belonged
            // to, so pending prefixes are discarded with it.
            if (parity_err || frame_err) begin
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
            end else if (r_byte_done) begin
                if (r_byte == PS2_EXT) begin
                    r_ext_pend <= 1'b1;
                end else if (r_byte == PS2_BRK) begin
                    r_brk_pend <= 1'b1;
                end else begin
                    r_ext_pend <= 1'b0;
                    r_brk_pend <= 1'b0;
                end
            end

            // A drop in the same cycle as a clear must remain visible.
            if (w_drop) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    key_event_t w_head;

    ps2_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .push       (w_push),
        .push_data  (w_push_evt),
        .push_drop  (w_drop),
        .pop_ready  (evt_ready),
        .head_valid (evt_valid),
        .head       (w_head),
        .count      (fifo_count)
    );

    assign evt_code  = w_head.code;
    assign evt_ext   = w_head.ext;
    assign evt_break = w_head.brk;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_rx_decoder
//  Purpose  : Self-checking bench for ps2_rx_decoder. Stimulus pushes the
//             expected key events into a scoreboard queue; an independent
//             monitor pops and compares whenever an event is handed over.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_decoder;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 400;
    localparam int FIFO_DEPTH  = 8;
    localparam int HALF        = 20;   // PS/2 half bit period in Clk cycles

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       evt_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic       evt_valid, evt_ext, evt_break, parity_err, frame_err, overflow;
    logic [7:0] evt_code;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    int checks = 0;
    int errors = 0;
    int par_pulses = 0;
    int frm_pulses = 0;
    logic [9:0] sb [$];   // expected {code, ext, brk}

    always #5 Clk = ~Clk;

    ps2_rx_decoder #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_ext    (evt_ext),
        .evt_break  (evt_break),
        .fifo_count (fifo_count),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .err_clr    (err_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Monitor: compares handed-over events and measures error pulse widths.
    initial begin : monitor
        logic [9:0] exp;
        int pw;
        int fw;
        pw = 0;
        fw = 0;
        forever begin
            @(negedge Clk);
            if (Reset_n && evt_valid && evt_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got 0x%0h expected none", {evt_code, evt_ext, evt_break});
                end else begin
                    exp = sb.pop_front();
                    check("event", {22'd0, evt_code, evt_ext, evt_break}, {22'd0, exp});
                end
            end
            if (parity_err) pw++;
            else if (pw != 0) begin
                check("parity_err_width", pw, 1);
                par_pulses++;
                pw = 0;
            end
            if (frame_err) fw++;
            else if (fw != 0) begin
                check("frame_err_width", fw, 1);
                frm_pulses++;
                fw = 0;
            end
        end
    end

    // One 11-bit frame. Options: corrupt parity/stop, glitch the clock line
    // during bit 4, measure evt_valid latency from the stop-bit falling edge,
    // or raise evt_ready for exactly the cycle in which the event is pushed.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit glitch, input bit measure, input bit coin_pop);
        logic [10:0] bits;
        int lat;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        lat = 0;
        for (int i = 0; i < 11; i++) begin
            ps2_data = bits[i];
            if (glitch && i == 4) begin
                tick(3);
                ps2_clk = 1'b0;
                tick(FILTER_LEN - 2);
                ps2_clk = 1'b1;
                tick(HALF - 3 - (FILTER_LEN - 2));
            end else begin
                tick(HALF);
            end
            ps2_clk = 1'b0;
            for (int c = 1; c <= HALF; c++) begin
                tick(1);
                if (i == 10) begin
                    if (measure && lat == 0 && evt_valid) lat = c;
                    if (coin_pop && c == FILTER_LEN + 3) evt_ready = 1'b1;
                    if (coin_pop && c == FILTER_LEN + 4) evt_ready = 1'b0;
                end
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        tick(2 * HALF);
        if (measure) check("valid_latency", lat, FILTER_LEN + 4);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Start bit plus nbits data bits, then the clock stays high.
    task automatic send_partial(input int nbits);
        for (int i = 0; i <= nbits; i++) begin
            ps2_data = (i == 0) ? 1'b0 : 1'b1;
            tick(HALF);
            ps2_clk = 1'b0;
            tick(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        tick(TIMEOUT_CYC + 2 * HALF);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            tick(1);
            n++;
        end
        check(name, sb.size(), 0);
        tick(2);
    endtask

    initial begin : stim
        int p0;
        int f0;

        // Reset state
        tick(3);
        check("rst_valid", evt_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_frame_err", frame_err, 0);
        Reset_n = 1'b1;
        tick(5);

        // Single make code, latency and occupancy
        sb.push_back({8'h1C, 1'b0, 1'b0});
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("make_count", fifo_count, 1);
        check("make_head_code", evt_code, 8'h1C);
        evt_ready = 1'b1;
        wait_drain("make_drain");
        check("make_count_after", fifo_count, 0);
        evt_ready = 1'b0;

        // Extended release E0 F0 75
        send_byte(8'hE0);
        send_byte(8'hF0);
        check("prefix_no_event", fifo_count, 0);
        sb.push_back({8'h75, 1'b1, 1'b1});
        send_byte(8'h75);
        check("ext_brk_count", fifo_count, 1);
        evt_ready = 1'b1;
        wait_drain("ext_brk_drain");

        // Parity error, then a good copy of the same byte
        p0 = par_pulses;
        send_frame(8'h29, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("parity_pulse", par_pulses - p0, 1);
        check("parity_no_event", fifo_count, 0);
        sb.push_back({8'h29, 1'b0, 1'b0});
        send_byte(8'h29);
        wait_drain("parity_recover");

        // Bad stop after E0 (clears ext), bad stop+parity gives frame_err only,
        // timeout on a partial frame, then F0 1C.
        f0 = frm_pulses;
        p0 = par_pulses;
        send_byte(8'hE0);
        send_frame(8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("stop_frame_pulse", frm_pulses - f0, 1);
        send_frame(8'h33, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("stop_priority_frame", frm_pulses - f0, 2);
        check("stop_priority_parity", par_pulses - p0, 0);
        send_partial(4);
        check("timeout_frame_pulse", frm_pulses - f0, 3);
        send_byte(8'hF0);
        sb.push_back({8'h1C, 1'b0, 1'b1});
        send_byte(8'h1C);
        wait_drain("break_after_err");

        // Clock glitch shorter than the filter
        sb.push_back({8'h5A, 1'b0, 1'b0});
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_drain("glitch_byte");

        // Overflow, clear, push coinciding with pop while full, ordered drain
        evt_ready = 1'b0;
        for (int k = 0; k < FIFO_DEPTH + 2; k++) begin
            if (k < FIFO_DEPTH) sb.push_back({8'h10 + 8'(k), 1'b0, 1'b0});
            send_byte(8'h10 + 8'(k));
        end
        check("full_count", fifo_count, FIFO_DEPTH);
        check("overflow_set", overflow, 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("overflow_clr", overflow, 0);
        sb.push_back({8'h20, 1'b0, 1'b0});
        send_frame(8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("coin_count", fifo_count, FIFO_DEPTH);
        check("coin_no_overflow", overflow, 0);
        evt_ready = 1'b1;
        wait_drain("overflow_drain");
        check("drained_valid", evt_valid, 0);

        // Reset with queued events discards them
        evt_ready = 1'b0;
        send_byte(8'h44);
        send_byte(8'h45);
        check("pre_reset_count", fifo_count, 2);
        Reset_n = 1'b0;
        #2;
        check("mid_reset_count", fifo_count, 0);
        check("mid_reset_valid", evt_valid, 0);
        tick(2);
        Reset_n = 1'b1;
        tick(5);
        sb.push_back({8'h16, 1'b0, 1'b0});
        send_byte(8'h16);
        evt_ready = 1'b1;
        wait_drain("post_reset_event");

        check("total_parity_pulses", par_pulses, 1);
        check("total_frame_pulses", frm_pulses, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_rx_decoder.md
Name: ps2_rx_decoder

Overview:
- Parametrised successor to the free-running PS/2 keyboard shift-register front end.
- Filters and synchronises the PS/2 clock and data lines, then frames each 11-bit packet with start, parity and stop checks.
- Folds E0 (extended) and F0 (break) prefixes into single key events and buffers them in a FIFO with a valid/ready interface.
- Sits between the PS/2 pins and the game control logic; replaces the raw keyCode/sR2data pair.

Parameters:
- FILTER_LEN, 8: consecutive equal Clk samples required before the filtered ps2 line changes state (>=2).
- TIMEOUT_CYC, 5000: Clk cycles without a filtered ps2_clk falling edge before an in-progress frame is abandoned (100 us at 50 MHz).
- FIFO_DEPTH, 8: key-event buffer depth; must be a power of two and >=2.

Ports:
- Clk, input, 1: system clock.
- Reset_n, input, 1: asynchronous, active-low reset.
- ps2_clk, input, 1: raw PS/2 clock pin, asynchronous to Clk.
- ps2_data, input, 1: raw PS/2 data pin, asynchronous to Clk.
- evt_valid, output, 1: head FIFO entry is valid.
- evt_ready, input, 1: consumer accepts the head entry.
- evt_code, output, 8: scan code of the head event.
- evt_ext, output, 1: the head event was E0-prefixed.
- evt_break, output, 1: the head event is a key release (F0-prefixed).
- fifo_count, output, $clog2(FIFO_DEPTH)+1: number of occupied FIFO entries.
- parity_err, output, 1: one-cycle pulse when a received frame fails odd parity.
- frame_err, output, 1: one-cycle pulse on a bad stop bit or a timeout.
- overflow, output, 1: sticky; set when an event is dropped because the FIFO is full.
- err_clr, input, 1: synchronous clear of overflow.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE; FIFO empty.
  - Filtered lines and synchronisers reset to 1 (bus idle).
- Synchronisation and filtering:
  - Both pins pass through a 2-FF synchroniser.
  - Each filtered line toggles only after FILTER_LEN consecutive synchronised samples that differ from its current value.
  - A sample edge is a 1->0 transition of the filtered clock; it is a single-cycle strobe.
- Frame FSM (acts only on sample edges, except timeout):
  - IDLE: data=0 -> DATA with bit count 0; data=1 -> stay in IDLE, no error.
  - DATA: shift data in LSB first; after the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: data=1 and the 9 bits hold an odd number of ones -> byte_done. Parity wrong -> parity_err pulse. data=0 -> frame_err pulse; this takes priority over the parity check. Every case returns to IDLE.
  - Timeout: in any state other than IDLE, a cycle counter reloads on each sample edge. On reaching TIMEOUT_CYC: -> IDLE, frame_err pulse, partial byte discarded.
- Prefix decoder (byte_done registered one cycle after the stop sample edge):
  - 0xE0 sets ext_pend; 0xF0 sets brk_pend; neither pushes an event.
  - Any other byte pushes {code, ext_pend, brk_pend} and clears both pending flags.
  - parity_err or frame_err clears both pending flags.
- Latency:
  - evt_valid rises 2 Clk cycles after the stop-bit sample edge when the FIFO was empty.
  - Head outputs are registered and are valid whenever evt_valid=1.
- FIFO:
  - A pop occurs when evt_valid & evt_ready.
  - A push is accepted when count<FIFO_DEPTH, or when count==FIFO_DEPTH and a pop occurs in the same cycle.
  - A rejected push drops the event and sets overflow.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Popping while empty is ignored.
- overflow:
  - err_clr clears it.
  - If a drop and err_clr coincide, the set wins.
- Reset mid-frame or mid-burst: immediate return to the reset state; FIFO contents are lost.

Decomposition:
- Package ps2_pkg:
  - State enum {IDLE, DATA, PARITY, STOP}.
  - Constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
  - Packed struct key_event_t {code[7:0], ext, brk}.
- One sub-module: ps2_event_fifo, parametrised on FIFO_DEPTH and storing key_event_t. Filter, FSM and decoder stay in the top module.

Test Plan:
- Single make 0x1C, odd parity correct -> one event: code=0x1C, ext=0, break=0; evt_valid 2 cycles after the stop edge; fifo_count=1.
- Sequence E0,F0,0x75 with evt_ready=0 -> one event: code=0x75, ext=1, break=1; no events for the prefix bytes.
- Frame 0x29 with flipped parity bit -> parity_err pulse of one cycle, no event. A following 0x29 with good parity -> normal event.
- Stop bit 0; separately, clock held high for TIMEOUT_CYC after 4 bits -> frame_err pulse each time, FSM in IDLE. Then F0,0x1C -> break event for 0x1C, no stale prefix.
- Glitch shorter than FILTER_LEN-1 cycles on ps2_clk -> no sample taken, received byte correct.
- FIFO_DEPTH+2 makes with evt_ready=0 -> fifo_count=FIFO_DEPTH and overflow=1; drain yields the first FIFO_DEPTH codes in order; err_clr clears overflow. A push coinciding with a pop while full is accepted.
